// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared scheduler state encoding, 1080p60 default timing and a
// counter-width helper used by the timing generator.
package hdmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // 1080p60 (CEA-861) timing, pixel clock 148.5 MHz
  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_H_FP     = 88;
  localparam int DEF_H_SYNC   = 44;
  localparam int DEF_H_BP     = 148;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 36;

  localparam int PIX_W = 24;
  localparam int UF_W  = 16;

  // Bits needed to hold the value n itself, so decode limits equal to the
  // total (zero back porch) still fit in the counter width.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: horizontal/vertical raster counters and raw
// (undelayed) active/sync decode.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   run          1 = counters free-run, 0 = counters held at (0,0)
//   active       current position is inside the active picture
//   hsync/vsync  raw active-high sync decode of the current position
//   origin       position is (0,0)
//   frame_end    position is (H_TOTAL-1, V_TOTAL-1)
module video_timing_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic origin,
  output logic frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync     = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vsync     = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign origin    = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/hdmi_pixel_scheduler.sv
// hdmi_pixel_scheduler: schedules pixel reads from a line buffer against the
// video raster and produces aligned sync / data-enable / pixel outputs.
// Ports:
//   tx_clock, tx_rst_n   pixel clock, async active-low reset (sync release)
//   enable               start/stop video; stop takes effect at frame end
//   pix_avail            buffer holds at least one line (gates RUN entry)
//   pix_req              read request, one pixel per high cycle
//   pix_data(_valid)     buffer response, one cycle after pix_req
//   vid_hsync/vsync/de   active-high timing outputs
//   vid_data             output pixel, 0 when missing or outside active
//   underflow_cnt        saturating count of missing pixels
//   busy                 state is not IDLE
//   fsm_state            current scheduler state (debug)
//
// Buffer handshake: pix_req is a request without backpressure; the buffer
// must answer every request cycle with pix_data_valid exactly one cycle
// later. A missing answer is an underflow; valid outside an expected slot
// is ignored.
//
// Pipeline: raster position at cycle t -> pix_req at t+1 -> pix_data at t+2
// -> vid_* at t+3. Syncs ride the same three stages so vid_de rises exactly
// two cycles after its pix_req in every state.
module hdmi_pixel_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             tx_clock,
  input  logic             tx_rst_n,
  input  logic             enable,
  input  logic             pix_avail,
  output logic             pix_req,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_data_valid,
  output logic             vid_hsync,
  output logic             vid_vsync,
  output logic             vid_de,
  output logic [PIX_W-1:0] vid_data,
  output logic [UF_W-1:0]  underflow_cnt,
  output logic             busy,
  output state_t           fsm_state
);

  // Reset: asserts asynchronously, releases two clock edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge tx_clock or negedge tx_rst_n) begin
    if (!tx_rst_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t state, state_nxt;
  logic   active, hsync, vsync, origin, frame_end;
  logic   slot1, hs1, vs1;
  logic   slot2, hs2, vs2;
  logic   miss, frame_uf;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (tx_clock),
    .rst_n     (rst_n),
    .run       (state != ST_IDLE),
    .active    (active),
    .hsync     (hsync),
    .vsync     (vsync),
    .origin    (origin),
    .frame_end (frame_end)
  );

  always_ff @(posedge tx_clock or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ARM->RUN is taken on the (0,0) cycle itself, so that pixel is requested.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_ARM;
      ST_ARM: begin
        if (origin && pix_avail && enable) state_nxt = ST_RUN;
        else if (frame_end && !enable)     state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (frame_end) begin
          if (!enable)               state_nxt = ST_IDLE;
          else if (frame_uf || miss) state_nxt = ST_ARM;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A slot exists only for active positions scheduled in RUN (including the
  // origin cycle that enters RUN). In-flight stages drain after leaving RUN.
  always_ff @(posedge tx_clock or negedge rst_n) begin
    if (!rst_n) begin
      slot1     <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      slot2     <= 1'b0;
      hs2       <= 1'b0;
      vs2       <= 1'b0;
      vid_de    <= 1'b0;
      vid_hsync <= 1'b0;
      vid_vsync <= 1'b0;
      vid_data  <= '0;
    end else begin
      slot1     <= active && (state_nxt == ST_RUN);
      hs1       <= hsync;
      vs1       <= vsync;
      slot2     <= slot1;
      hs2       <= hs1;
      vs2       <= vs1;
      vid_de    <= slot2;
      vid_hsync <= hs2;
      vid_vsync <= vs2;
      vid_data  <= (slot2 && pix_data_valid) ? pix_data : '0;
    end
  end

  assign pix_req = slot1;
  assign miss    = slot2 && !pix_data_valid;

  always_ff @(posedge tx_clock or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= '0;
      frame_uf      <= 1'b0;
    end else begin
      if (miss && (underflow_cnt != {UF_W{1'b1}}))
        underflow_cnt <= underflow_cnt + UF_W'(1);
      // Per-frame flag feeds the resync decision; cleared once consumed.
      if (frame_end)  frame_uf <= 1'b0;
      else if (miss)  frame_uf <= 1'b1;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule
